// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like bus between instruction fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_rdata_valid,
  input  logic                data_en,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wmask,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rdata_valid,
  output logic                data_write_finish,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wmask,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_bvalid
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_data_q;   // 1: data port owns the bus, 0: instruction port
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  drop_q;
  logic [STREAK_W-1:0]   streak_q;

  logic grant_data;
  logic grant_inst;
  logic resp_hit;
  logic inst_flushed;

  // An instruction transaction caught by flush after acceptance must finish on the bus silently
  assign inst_flushed = !owner_data_q && flush &&
                        ((state_q == WAIT) || (state_q == RESP) ||
                         ((state_q == REQ) && bus_ack));

  // Next-state and grant decision; data wins unless instruction fetch has been starved too long
  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    resp_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_en && (!inst_en || (streak_q < STREAK_MAX))) begin
          grant_data = 1'b1;
          state_d    = REQ;
        end else if (inst_en && !flush) begin
          grant_inst = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = WAIT;
        end else if (!owner_data_q && flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        resp_hit = we_q ? bus_bvalid : bus_rvalid;
        if (resp_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted request so the bus fields stay stable until acked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
    end else if (grant_data) begin
      owner_data_q <= 1'b1;
      we_q         <= data_we;
      addr_q       <= data_addr;
      wmask_q      <= data_wmask;
      wdata_q      <= data_wdata;
    end else if (grant_inst) begin
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= inst_addr;
      wmask_q      <= '0;
      wdata_q      <= '0;
    end
  end

  // Count data grants made while fetch waits; fetch is forced through once the count saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (grant_data) begin
      if (!inst_en) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end else if (grant_inst) begin
      streak_q <= '0;
    end
  end

  // Drop flag silences the completion pulse of a flushed instruction fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else if (state_d == IDLE) begin
      drop_q <= 1'b0;
    end else if (inst_flushed) begin
      drop_q <= 1'b1;
    end
  end

  // Capture response data; both rdata outputs show the last captured value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (resp_hit) begin
      rdata_q <= bus_rdata;
    end
  end

  assign bus_req           = (state_q == REQ);
  assign bus_we            = we_q;
  assign bus_addr          = addr_q;
  assign bus_wmask         = wmask_q;
  assign bus_wdata         = wdata_q;
  assign inst_rdata        = rdata_q;
  assign data_rdata        = rdata_q;
  assign inst_rdata_valid  = (state_q == RESP) && !owner_data_q && !drop_q;
  assign data_rdata_valid  = (state_q == RESP) && owner_data_q && !we_q;
  assign data_write_finish = (state_q == RESP) && owner_data_q && we_q;

endmodule
